// File: rtl/fir_out_decim.sv
// Output stage for fir_shiftreg: decimate, round/rescale, narrow, buffer in an FWFT FIFO.
// Define FIR_SAT_EN to clamp the rescaled value instead of wrapping it.
module fir_out_decim #(
    parameter int IN_W       = 11,
    parameter int OUT_W      = 8,
    parameter int DECIM      = 2,
    parameter int SHIFT      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic signed [IN_W-1:0]               in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [OUT_W-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 ovf_sticky,
    input  logic                                 clr_ovf
);

    localparam int PW      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = $clog2(FIFO_DEPTH + 1);
    localparam int RND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
    localparam logic signed [IN_W:0] RND = (IN_W + 1)'(RND_INT);

    logic [PW-1:0]          phase;
    logic                   keep;
    logic signed [IN_W:0]   sum;
    logic signed [OUT_W-1:0] scaled;

    logic                   s1_valid;
    logic signed [OUT_W-1:0] s1_data;

    logic [OUT_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic                   drop;

    assign keep = in_valid && (phase == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
        end
    end

    // One guard bit so the rounding add cannot overflow before the shift.
    assign sum = $signed({in_data[IN_W-1], in_data}) + RND;

`ifdef FIR_SAT_EN
    localparam logic signed [IN_W:0] MAXV = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MINV = -MAXV - (IN_W + 1)'(1);

    logic signed [IN_W:0] shifted;
    assign shifted = sum >>> SHIFT;

    always_comb begin
        scaled = OUT_W'(shifted);
        if (shifted > MAXV) begin
            scaled = OUT_W'(MAXV);
        end else if (shifted < MINV) begin
            scaled = OUT_W'(MINV);
        end
    end
`else
    assign scaled = OUT_W'(sum >>> SHIFT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_data <= scaled;
            end
        end
    end

    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign wr_en     = s1_valid && (!full || pop);
    assign drop      = s1_valid && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (drop) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: queue-based model checked every cycle on a DECIM=2 instance,
// plus directed literal checks on both the DECIM=2 and a DECIM=1 instance.
module tb_fir_out_decim;

    localparam int DEPTH = 4;
    localparam int DEC   = 2;
    localparam int SH    = 3;
`ifdef FIR_SAT_EN
    localparam int SATHI = 127;
`else
    localparam int SATHI = -128;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, out_ready, clr_ovf;
    logic signed [10:0] in_data;
    logic              out_valid, ovf_sticky;
    logic signed [7:0]  out_data;
    logic [2:0]         fifo_level;

    logic              v1, r1;
    logic signed [10:0] d1;
    logic              ov1, ovf1;
    logic signed [7:0]  od1;
    logic [2:0]         lvl1;

    int cmp_n = 0;
    int err_n = 0;
    int got[$];
    int got1[$];

    always #5 clk = ~clk;

    fir_out_decim #(.IN_W(11), .OUT_W(8), .DECIM(DEC), .SHIFT(SH), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
    );

    fir_out_decim #(.IN_W(11), .OUT_W(8), .DECIM(1), .SHIFT(SH), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1),
        .out_valid(ov1), .out_ready(r1), .out_data(od1),
        .fifo_level(lvl1), .ovf_sticky(ovf1), .clr_ovf(1'b0)
    );

    task automatic chk(input int act, input int exp, input string nm);
        cmp_n++;
        if (act != exp) begin
            err_n++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Rounded divide by 2^SH (floor of x/2^SH + 1/2), then saturate or wrap to 8 bits.
    function automatic int model_scale(input int x);
        int div, t, r;
        div = 1 << SH;
        t   = x + div / 2;
        r   = (t >= 0) ? t / div : -((-t + div - 1) / div);
`ifdef FIR_SAT_EN
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`else
        r = ((r + 128) % 256 + 256) % 256 - 128;
`endif
        return r;
    endfunction

    // Model: count of valid inputs, one-stage pipeline, FIFO as a queue.
    int  q[$];
    int  vcnt;
    bit  m_s1v;
    int  m_s1d;
    bit  m_ovf;
    bit  m_pop, m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            vcnt  = 0;
            m_s1v = 0;
            m_ovf = 0;
        end else begin
            if (out_valid && out_ready) got.push_back(int'(out_data));
            m_pop  = (q.size() > 0) && out_ready;
            m_drop = m_s1v && (q.size() == DEPTH) && !m_pop;
            if (m_pop) void'(q.pop_front());
            if (m_s1v && !m_drop) q.push_back(m_s1d);
            if (m_drop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_s1v = in_valid && (vcnt % DEC == 0);
            m_s1d = model_scale(int'(in_data));
            if (in_valid) vcnt++;
        end
        #1;
        chk(int'(out_valid), (q.size() > 0) ? 1 : 0, "m_out_valid");
        chk(int'(out_data), (q.size() > 0) ? q[0] : 0, "m_out_data");
        chk(int'(fifo_level), q.size(), "m_fifo_level");
        chk(int'(ovf_sticky), int'(m_ovf), "m_ovf_sticky");
    end

    always @(posedge clk) begin
        if (!rst && ov1 && r1) got1.push_back(int'(od1));
    end

    task automatic step(input logic v, input int d, input logic rdy, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = 11'(d);
        out_ready = rdy;
        clr_ovf   = clr;
    endtask

    task automatic step1(input logic v, input int d, input logic rdy);
        @(negedge clk);
        v1 = v;
        d1 = 11'(d);
        r1 = rdy;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = '0; out_ready = 0; clr_ovf = 0;
        v1 = 0; d1 = '0; r1 = 0;
        #1;
        chk(int'(out_valid), 0, "rst_out_valid");
        chk(int'(out_data), 0, "rst_out_data");
        chk(int'(fifo_level), 0, "rst_fifo_level");
        chk(int'(ovf_sticky), 0, "rst_ovf");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Decimation and latency
        got.delete();
        step(1, 8, 1, 0);
        step(1, 16, 1, 0);
        chk(int'(out_valid), 0, "t1_lat_edge1");
        step(1, 24, 1, 0);
        chk(int'(out_valid), 1, "t1_lat_edge2");
        chk(int'(out_data), 1, "t1_first_data");
        step(1, 32, 1, 0);
        repeat (4) step(0, 0, 1, 0);
        chk(got.size(), 2, "t1_count");
        chk(got[0], 1, "t1_out0");
        chk(got[1], 3, "t1_out1");

        // Range limits
        got.delete();
        step(1, 1023, 1, 0);
        step(1, 5, 1, 0);
        step(1, -1024, 1, 0);
        step(1, 7, 1, 0);
        repeat (4) step(0, 0, 1, 0);
        chk(got.size(), 2, "t3_count");
        chk(got[0], SATHI, "t3_max");
        chk(got[1], -128, "t3_min");

        // Overflow with stalled consumer
        for (int i = 0; i < 20; i++) step(1, (i + 1) * 8, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        chk(int'(fifo_level), 4, "t4_level_full");
        chk(int'(ovf_sticky), 1, "t4_ovf_set");
        got.delete();
        repeat (6) step(0, 0, 1, 0);
        chk(got.size(), 4, "t4_count");
        for (int i = 0; i < 4; i++) chk(got[i], 2 * i + 1, "t4_order");
        chk(int'(ovf_sticky), 1, "t4_ovf_hold");
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        chk(int'(ovf_sticky), 0, "t4_ovf_clr");

        // Rounding on the DECIM=1 instance
        got1.delete();
        step1(1, 12, 1);
        step1(1, -12, 1);
        step1(1, 4, 1);
        step1(1, -4, 1);
        repeat (4) step1(0, 0, 1);
        chk(got1.size(), 4, "t2_count");
        chk(got1[0], 2, "t2_p12");
        chk(got1[1], -1, "t2_m12");
        chk(got1[2], 1, "t2_p4");
        chk(got1[3], 0, "t2_m4");

        // Full FIFO with simultaneous write and pop every cycle
        got1.delete();
        for (int k = 1; k <= 5; k++) step1(1, 8 * k, 0);
        for (int k = 6; k <= 12; k++) begin
            step1(1, 8 * k, 1);
            if (k >= 7) begin
                chk(int'(lvl1), 4, "t5_level");
                chk(int'(ovf1), 0, "t5_ovf");
            end
        end
        step1(0, 0, 1);
        chk(int'(lvl1), 4, "t5_level_last");
        repeat (8) step1(0, 0, 1);
        chk(int'(lvl1), 0, "t5_drained");
        chk(got1.size(), 12, "t5_count");
        for (int k = 1; k <= 12; k++) chk(got1[k-1], k, "t5_order");

        // Reset mid-operation
        for (int i = 0; i < 5; i++) step(1, (i + 1) * 8, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        chk(int'(fifo_level), 3, "t6_level_pre");
        #2 rst = 1'b1;
        #1;
        chk(int'(out_valid), 0, "t6_rst_valid");
        chk(int'(fifo_level), 0, "t6_rst_level");
        @(negedge clk);
        rst = 1'b0;
        step(1, 40, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk(int'(out_valid), 1, "t6_valid_after");
        chk(int'(out_data), 5, "t6_data_after");
        repeat (3) step(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
